nibble_serial_tx: RTL and testbench

Parallel-to-serial transmitter for the per-bit registered parallel capture path. It accepts a DATA_W-bit word over a valid/ready handshake and shifts it out LSB-first on a single serial line, with a frame strobe marking the data bits. An optional even-parity bit follows the data. A programmable idle gap separates consecutive frames. The block sits on the sending side of the link; the downstream receiver samples `ser_out` while `ser_frame` is high.

---
 rtl/nibble_serial_tx.sv | 157 +++++++++++++++
 tb/tb_nibble_serial_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_tx.sv
// LSB-first parallel-to-serial transmitter with a valid/ready input and a programmable idle gap.
// Define NIBBLE_SERIAL_TX_PARITY_EN to append an even-parity bit after the data bits.
module nibble_serial_tx #(
  parameter int DATA_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_out,
  output logic              ser_frame,
  output logic              busy
);

  localparam int               CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [7:0]       LAST_GAP  = 8'(GAP_CYCLES - 1);
  localparam logic             POST_IDLE = 1'(GAP_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_GAP    = 2'd3
  } state_e;

  // With no gap configured the frame ends straight in IDLE.
  localparam state_e POST_FRAME_ST = POST_IDLE ? ST_IDLE : ST_GAP;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_frame_q, ser_frame_d;
  logic              busy_q, busy_d;

`ifdef NIBBLE_SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;

  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    even_parity = ^word;
  endfunction
`endif

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    in_ready_d  = 1'b0;
    ser_out_d   = 1'b0;
    ser_frame_d = 1'b0;
    busy_d      = 1'b1;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d     = ST_SHIFT;
          sreg_d      = in_data;
          bit_cnt_d   = '0;
          ser_out_d   = in_data[0];
          ser_frame_d = 1'b1;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
          parity_d    = even_parity(in_data);
`endif
        end else begin
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
          state_d     = ST_PARITY;
          ser_out_d   = parity_q;
          ser_frame_d = 1'b1;
`else
          state_d    = POST_FRAME_ST;
          gap_cnt_d  = 8'd0;
          in_ready_d = POST_IDLE;
          busy_d     = ~POST_IDLE;
`endif
        end else begin
          sreg_d      = sreg_q >> 1;
          ser_out_d   = sreg_d[0];
          ser_frame_d = 1'b1;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        end
      end
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        state_d    = POST_FRAME_ST;
        gap_cnt_d  = 8'd0;
        in_ready_d = POST_IDLE;
        busy_d     = ~POST_IDLE;
      end
`endif
      ST_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= 8'd0;
      in_ready_q  <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_frame_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      in_ready_q  <= in_ready_d;
      ser_out_q   <= ser_out_d;
      ser_frame_q <= ser_frame_d;
      busy_q      <= busy_d;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign ser_out   = ser_out_q;
  assign ser_frame = ser_frame_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Scoreboard bench for nibble_serial_tx: three configurations driven with random traffic,
// expected serial bits queued at accept time and popped by a monitor on every framed bit.
module tb_nibble_serial_tx;

  localparam int NI = 3;
  localparam int DW [NI] = '{4, 8, 4};
  localparam int GP [NI] = '{1, 3, 0};
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld [NI];
  logic [31:0] dat [NI];
  logic        rdy [NI];
  logic        so  [NI];
  logic        sf  [NI];
  logic        bz  [NI];

  bit          exp_q [NI][$];
  logic [31:0] dir_q [NI][$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        done_chk = 1'b0;
  logic        traffic_timeout = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    nibble_serial_tx #(.DATA_W(DW[g]), .GAP_CYCLES(GP[g])) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (vld[g]),
      .in_ready (rdy[g]),
      .in_data  (dat[g][DW[g]-1:0]),
      .ser_out  (so[g]),
      .ser_frame(sf[g]),
      .busy     (bz[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a frame is the DW data bits LSB first, then the XOR of them when parity is built in.
  task automatic push_word(input int n, input logic [31:0] w);
    bit p;
    p = 1'b0;
    for (int b = 0; b < DW[n]; b++) begin
      exp_q[n].push_back(w[b]);
      p ^= w[b];
    end
    if (PAR != 0) exp_q[n].push_back(p);
  endtask

  // Monitor: per-instance frame length, bit values, gap length and reset behaviour.
  int bits_seen [NI];
  int gap_seen  [NI];
  int since_rel [NI];
  int stall     [NI];
  bit post_frame[NI];
  bit final_done = 1'b0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      for (int n = 0; n < NI; n++) begin
        chk($sformatf("rst_ready[%0d]", n), rdy[n], 32'd0);
        chk($sformatf("rst_out[%0d]", n), so[n], 32'd0);
        chk($sformatf("rst_frame[%0d]", n), sf[n], 32'd0);
        chk($sformatf("rst_busy[%0d]", n), bz[n], 32'd0);
        bits_seen[n] = 0; gap_seen[n] = 0; since_rel[n] = 0; stall[n] = 0; post_frame[n] = 1'b0;
      end
    end else begin
      for (int n = 0; n < NI; n++) begin
        if (since_rel[n] < 3) since_rel[n]++;
        if (since_rel[n] == 1) chk($sformatf("ready_before_edge[%0d]", n), rdy[n], 32'd0);
        if (since_rel[n] == 2) chk($sformatf("ready_after_edge[%0d]", n), rdy[n], 32'd1);
        if (sf[n]) begin
          chk($sformatf("busy_in_frame[%0d]", n), bz[n], 32'd1);
          chk($sformatf("ready_in_frame[%0d]", n), rdy[n], 32'd0);
          chk($sformatf("bits_pending[%0d]", n), 32'(exp_q[n].size() > 0), 32'd1);
          if (exp_q[n].size() > 0) chk($sformatf("ser_bit[%0d]", n), so[n], 32'(exp_q[n].pop_front()));
          bits_seen[n]++;
          stall[n] = 0;
        end else begin
          chk($sformatf("idle_out[%0d]", n), so[n], 32'd0);
          if (bits_seen[n] != 0) begin
            chk($sformatf("frame_len[%0d]", n), bits_seen[n], 32'(DW[n] + PAR));
            bits_seen[n] = 0; gap_seen[n] = 0; post_frame[n] = 1'b1;
          end
          if (post_frame[n]) begin
            if (rdy[n]) begin
              chk($sformatf("gap_len[%0d]", n), gap_seen[n], 32'(GP[n]));
              post_frame[n] = 1'b0;
            end else begin
              gap_seen[n]++;
              chk($sformatf("busy_in_gap[%0d]", n), bz[n], 32'd1);
              chk($sformatf("gap_bound[%0d]", n), 32'(gap_seen[n] <= GP[n]), 32'd1);
              if (gap_seen[n] > GP[n]) post_frame[n] = 1'b0;
            end
          end
          if (rdy[n]) chk($sformatf("busy_when_ready[%0d]", n), bz[n], 32'd0);
          if (exp_q[n].size() > 0) begin
            stall[n]++;
            chk($sformatf("stall_budget[%0d]", n), 32'(stall[n] <= 50), 32'd1);
            if (stall[n] > 50) begin
              exp_q[n].delete();
              stall[n] = 0;
            end
          end
        end
      end
      if (done_chk && !final_done) begin
        for (int n = 0; n < NI; n++) chk($sformatf("queue_drained[%0d]", n), exp_q[n].size(), 32'd0);
        chk("traffic_in_budget", traffic_timeout, 32'd0);
        final_done = 1'b1;
      end
    end
  end

  // Random traffic: directed words first, then random ones; valid often stays high back to back.
  task automatic run_traffic(input int nwords);
    int   sent [NI];
    logic acc  [NI];
    int   cyc;
    for (int n = 0; n < NI; n++) sent[n] = 0;
    cyc = 0;
    while (cyc < 4000 && (sent[0] < nwords || sent[1] < nwords || sent[2] < nwords)) begin
      @(negedge clk);
      for (int n = 0; n < NI; n++) begin
        acc[n] = vld[n] && rdy[n];
        if (acc[n]) push_word(n, dat[n]);
      end
      @(posedge clk);
      #1;
      for (int n = 0; n < NI; n++) begin
        if (acc[n]) begin
          sent[n]++;
          vld[n] = 1'b0;
        end
        if (!vld[n]) begin
          if (sent[n] < nwords && (dir_q[n].size() > 0 || $urandom_range(0, 3) != 0)) begin
            vld[n] = 1'b1;
            dat[n] = (dir_q[n].size() > 0) ? dir_q[n].pop_front() : $urandom;
          end else begin
            dat[n] = $urandom;
          end
        end
      end
      cyc++;
    end
    if (cyc >= 4000) traffic_timeout = 1'b1;
    for (int n = 0; n < NI; n++) vld[n] = 1'b0;
  endtask

  initial begin
    logic got_acc;
    rst_n = 1'b0;
    for (int n = 0; n < NI; n++) begin
      vld[n] = 1'b0;
      dat[n] = 32'd0;
    end
    dir_q[0].push_back(32'hB);
    dir_q[0].push_back(32'h6);
    dir_q[0].push_back(32'h0);
    dir_q[0].push_back(32'hF);
    dir_q[1].push_back(32'h81);
    dir_q[2].push_back(32'hA);
    dir_q[2].push_back(32'h5);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    run_traffic(30);
    repeat (40) @(posedge clk);

    // Reset during bit 2 of 4'hF on the first instance.
    #1;
    vld[0] = 1'b1;
    dat[0] = 32'hF;
    got_acc = 1'b0;
    for (int k = 0; k < 20 && !got_acc; k++) begin
      @(negedge clk);
      if (vld[0] && rdy[0]) begin
        push_word(0, dat[0]);
        got_acc = 1'b1;
      end
    end
    if (!got_acc) traffic_timeout = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    dat[0] = $urandom;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    for (int n = 0; n < NI; n++) exp_q[n].delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    dir_q[0].push_back(32'h3);
    run_traffic(3);
    repeat (40) @(posedge clk);

    done_chk = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
